// File: rtl/dti_fifo_if.sv
// dti: data/valid/ready channel between two DTI endpoints.
// producer drives data/valid and samples ready; consumer is the mirror.
interface dti #(
  parameter int W_DATA = 64
);
  logic [W_DATA-1:0] data;
  logic              valid;
  logic              ready;

  modport producer (
    output data,
    output valid,
    input  ready
  );

  modport consumer (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/dti_fifo.sv
// dti_fifo: DEPTH-entry first-word-fall-through FIFO between DTI channels.
// Ports: clk, rst_n (async low), din (dti.consumer), dout (dti.producer),
// level (occupancy, only when DTI_FIFO_LEVEL_EN is defined).
module dti_fifo #(
  parameter int W_DATA = 64,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  dti.consumer din,
  dti.producer dout
`ifdef DTI_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dti_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [AW:0]       r_wp;
  logic [AW:0]       r_rp;
  logic [W_DATA-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Extra MSB distinguishes full from empty
  // when the low pointer bits coincide.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0])
                && (r_wp[AW] != r_rp[AW]);

  assign w_push = din.valid && !w_full;
  assign w_pop  = dout.ready && !w_empty;

  assign din.ready  = !w_full;
  assign dout.valid = !w_empty;
  assign dout.data  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
    end else if (w_push) begin
      r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rp <= '0;
    end else if (w_pop) begin
      r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= din.data;
    end
  end

`ifdef DTI_FIFO_LEVEL_EN
  assign level = r_wp - r_rp;
`endif

endmodule
